// File: rtl/note_seq_pkg.sv
// +----------------------------------------------------------------------+
// | note_seq_pkg : shared types for the note sequencer                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

package note_seq_pkg;

  localparam int unsigned c_NOTE_W = 4;
  localparam int unsigned c_OCT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [c_OCT_W-1:0]  octave;
    logic [c_NOTE_W-1:0] note;
  } note_entry_t;

endpackage

`default_nettype wire

// File: rtl/note_ram.sv
// +----------------------------------------------------------------------+
// | note_ram : DEPTH x WIDTH note store, one write port, registered read   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module note_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_rd_load,
  input  logic                     i_rd_keep,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read register doubles as the output register: it is zero whenever no note is sounding.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           r_rdata <= '0;
    else if (i_rd_load)  r_rdata <= r_mem[i_raddr];
    else if (!i_rd_keep) r_rdata <= '0;
  end

  assign o_rdata = r_rdata;

endmodule

`default_nettype wire

// File: rtl/note_sequencer.sv
// +----------------------------------------------------------------------+
// | note_sequencer : records {octave,note} entries and plays them back,    |
// | holding each for tick_len cycles. Optional looping via SEQ_LOOP_EN.    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NOTE_W = 4,
  parameter int OCT_W  = 2,
  parameter int TICK_W = 24
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_rec_valid,
  output logic                     o_rec_ready,
  input  logic [NOTE_W-1:0]        i_note_in,
  input  logic [OCT_W-1:0]         i_octave_in,
  input  logic                     i_clear,
  input  logic                     i_play_start,
  input  logic                     i_stop,
  input  logic                     i_loop,
  input  logic [TICK_W-1:0]        i_tick_len,
  output logic                     o_play_valid,
  output logic [NOTE_W-1:0]        o_note_out,
  output logic [OCT_W-1:0]         o_octave_out,
  output logic [$clog2(DEPTH)-1:0] o_play_idx,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_done
);

  localparam int              c_AW        = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_CNT_ONE   = (c_AW+1)'(1);
  localparam logic [c_AW:0]   c_CNT_DEPTH = (c_AW+1)'(DEPTH);
  localparam logic [c_AW-1:0] c_IDX_ONE   = c_AW'(1);

  seq_state_t                r_state;
  logic [c_AW:0]             r_count;
  logic [c_AW-1:0]           r_play_idx;
  logic                      r_play_valid;
  logic                      r_done;
  logic [TICK_W-1:0]         r_remain;

  logic                      w_full;
  logic                      w_rec_ready;
  logic                      w_wr_en;
  logic                      w_last;
  logic                      w_expire;
  logic                      w_rd_load;
  logic                      w_rd_keep;
  logic [TICK_W-1:0]         w_tick_init;
  logic [OCT_W+NOTE_W-1:0]   w_rd_data;

  assign w_full      = (r_count == c_CNT_DEPTH);
  assign w_rec_ready = (r_state == S_IDLE) & ~w_full & ~i_stop & ~i_clear & ~i_play_start;
  assign w_wr_en     = i_rec_valid & w_rec_ready;
  assign w_last      = (({1'b0, r_play_idx} + c_CNT_ONE) == r_count);
  assign w_expire    = (r_state == S_HOLD) & (r_remain == '0);
  assign w_tick_init = (i_tick_len == '0) ? '0 : i_tick_len - TICK_W'(1);
  assign w_rd_load   = (r_state == S_FETCH) & ~i_stop;
  assign w_rd_keep   = (r_state == S_HOLD) & ~i_stop & ~w_expire;

  note_ram #(
    .DEPTH (DEPTH),
    .WIDTH (OCT_W + NOTE_W)
  ) u_ram (
    .clk       (clk),
    .reset     (reset),
    .i_we      (w_wr_en),
    .i_waddr   (r_count[c_AW-1:0]),
    .i_wdata   ({i_octave_in, i_note_in}),
    .i_rd_load (w_rd_load),
    .i_rd_keep (w_rd_keep),
    .i_raddr   (r_play_idx),
    .o_rdata   (w_rd_data)
  );

`ifndef SEQ_LOOP_EN
  logic w_unused_loop;
  assign w_unused_loop = i_loop;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_play_idx   <= '0;
      r_play_valid <= 1'b0;
      r_done       <= 1'b0;
      r_remain     <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!i_stop) begin
            if (i_clear) begin
              r_count <= '0;
            end else if (i_play_start) begin
              if (r_count != '0) begin
                r_state    <= S_FETCH;
                r_play_idx <= '0;
              end else begin
                r_done <= 1'b1;
              end
            end else if (w_wr_en) begin
              r_count <= r_count + c_CNT_ONE;
            end
          end
        end
        S_FETCH: begin
          if (i_stop) begin
            r_state <= S_IDLE;
          end else begin
            r_state      <= S_HOLD;
            r_play_valid <= 1'b1;
            r_remain     <= w_tick_init;
          end
        end
        S_HOLD: begin
          if (i_stop) begin
            r_state      <= S_IDLE;
            r_play_valid <= 1'b0;
          end else if (w_expire) begin
            r_play_valid <= 1'b0;
            if (!w_last) begin
              r_play_idx <= r_play_idx + c_IDX_ONE;
              r_state    <= S_FETCH;
            end
`ifdef SEQ_LOOP_EN
            else if (i_loop) begin
              r_play_idx <= '0;
              r_state    <= S_FETCH;
            end
`endif
            else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end else begin
            r_remain <= r_remain - TICK_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rec_ready  = w_rec_ready;
  assign o_full       = w_full;
  assign o_play_valid = r_play_valid;
  assign o_note_out   = w_rd_data[NOTE_W-1:0];
  assign o_octave_out = w_rd_data[OCT_W+NOTE_W-1:NOTE_W];
  assign o_play_idx   = r_play_idx;
  assign o_count      = r_count;
  assign o_done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_note_sequencer.sv
// +----------------------------------------------------------------------+
// | tb_note_sequencer : randomized self-checking bench for note_sequencer  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int DEPTH  = 16;
  localparam int NOTE_W = 4;
  localparam int OCT_W  = 2;
  localparam int TICK_W = 24;
  localparam int AW     = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              rec_valid, rec_ready, clear, play_start, stop, loop_i;
  logic [NOTE_W-1:0] note_in, note_out;
  logic [OCT_W-1:0]  octave_in, octave_out;
  logic [TICK_W-1:0] tick_len;
  logic              play_valid, full, done;
  logic [AW-1:0]     play_idx;
  logic [AW:0]       count;

  int checks = 0;
  int errors = 0;
  note_entry_t model[$];

  always #5 clk = ~clk;

  note_sequencer #(
    .DEPTH(DEPTH), .NOTE_W(NOTE_W), .OCT_W(OCT_W), .TICK_W(TICK_W)
  ) dut (
    .clk(clk), .reset(reset),
    .i_rec_valid(rec_valid), .o_rec_ready(rec_ready),
    .i_note_in(note_in), .i_octave_in(octave_in),
    .i_clear(clear), .i_play_start(play_start), .i_stop(stop), .i_loop(loop_i),
    .i_tick_len(tick_len),
    .o_play_valid(play_valid), .o_note_out(note_out), .o_octave_out(octave_out),
    .o_play_idx(play_idx), .o_count(count), .o_full(full), .o_done(done)
  );

  task automatic record(input logic [NOTE_W-1:0] n, input logic [OCT_W-1:0] o);
    note_entry_t e;
    @(negedge clk); rec_valid = 1'b1; note_in = n; octave_in = o;
    @(negedge clk); rec_valid = 1'b0;
    e.note = n; e.octave = o;
    if (model.size() < DEPTH) model.push_back(e);
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (play_valid !== 1'b0) begin errors++; $display("FAIL reset_pv got %0b want 0", play_valid); end
    checks++; if (count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++; if ({note_out, octave_out, play_idx, done} !== '0) begin errors++;
      $display("FAIL reset_outs note %0d oct %0d idx %0d done %0b want all 0", note_out, octave_out, play_idx, done); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %0b want 0", full); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Expected trace per slot: one silent fetch cycle, then max(tick,1) cycles of the note; then done.
  task automatic test_playback(input int tick);
    int hold = (tick == 0) ? 1 : tick;
    int n = model.size();
    @(negedge clk); tick_len = TICK_W'(tick); play_start = 1'b1;
    @(negedge clk); play_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      checks++;
      if (play_valid !== 1'b0 || done !== 1'b0 || note_out !== '0 || play_idx !== AW'(i)) begin errors++;
        $display("FAIL play_gap slot %0d got pv %0b done %0b note %0d idx %0d want 0 0 0 %0d",
                 i, play_valid, done, note_out, play_idx, i); end
      @(negedge clk);
      for (int k = 0; k < hold; k++) begin
        checks++;
        if (play_valid !== 1'b1 || done !== 1'b0 || note_out !== model[i].note ||
            octave_out !== model[i].octave || play_idx !== AW'(i)) begin errors++;
          $display("FAIL play_note slot %0d cyc %0d got pv %0b done %0b note %0d oct %0d idx %0d want 1 0 %0d %0d %0d",
                   i, k, play_valid, done, note_out, octave_out, play_idx, model[i].note, model[i].octave, i); end
        @(negedge clk);
      end
    end
    checks++;
    if (play_valid !== 1'b0 || done !== 1'b1) begin errors++;
      $display("FAIL play_done got pv %0b done %0b want 0 1", play_valid, done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL play_done_pulse got %0b want 0", done); end
  endtask

  task automatic test_directed_notes();
    do_clear();
    record(4'd1, 2'd0); record(4'd5, 2'd1); record(4'd9, 2'd3);
    checks++; if (count !== 5'd3) begin errors++; $display("FAIL dir_count got %0d want 3", count); end
    test_playback(4);
  endtask

  task automatic test_full();
    do_clear();
    for (int i = 0; i < DEPTH; i++) record(NOTE_W'($urandom), OCT_W'($urandom));
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL full_flag got %0b want 1", full); end
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d want 16", count); end
    checks++; if (rec_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %0b want 0", rec_ready); end
    record(4'hF, 2'd3);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_overflow got %0d want 16", count); end
    test_playback(1);
  endtask

  task automatic test_empty_play();
    do_clear();
    checks++; if (count !== '0) begin errors++; $display("FAIL clear_count got %0d want 0", count); end
    @(negedge clk); play_start = 1'b1;
    @(negedge clk); play_start = 1'b0;
    checks++; if (done !== 1'b1 || play_valid !== 1'b0) begin errors++;
      $display("FAIL empty_done got done %0b pv %0b want 1 0", done, play_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || play_valid !== 1'b0) begin errors++;
        $display("FAIL empty_quiet got done %0b pv %0b want 0 0", done, play_valid); end
    end
  endtask

  task automatic test_stop();
    do_clear();
    for (int i = 0; i < 3; i++) record(NOTE_W'($urandom), OCT_W'($urandom));
    @(negedge clk); tick_len = 24'd4; play_start = 1'b1;
    @(negedge clk); play_start = 1'b0;
    repeat (7) @(negedge clk);
    checks++; if (play_valid !== 1'b1 || play_idx !== 4'd1 || note_out !== model[1].note) begin errors++;
      $display("FAIL stop_pre got pv %0b idx %0d note %0d want 1 1 %0d", play_valid, play_idx, note_out, model[1].note); end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    #1;
    checks++; if (play_valid !== 1'b0 || done !== 1'b0 || note_out !== '0 || rec_ready !== 1'b1) begin errors++;
      $display("FAIL stop_idle got pv %0b done %0b note %0d ready %0b want 0 0 0 1", play_valid, done, note_out, rec_ready); end
    repeat (3) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || play_valid !== 1'b0) begin errors++;
        $display("FAIL stop_nodone got done %0b pv %0b want 0 0", done, play_valid); end
    end
    test_playback(4);
  endtask

  task automatic test_priority();
    do_clear();
    record(4'd3, 2'd2); record(4'd7, 2'd1);
    @(negedge clk); clear = 1'b1; rec_valid = 1'b1; note_in = 4'd12; #1;
    checks++; if (rec_ready !== 1'b0) begin errors++; $display("FAIL clr_ready got %0b want 0", rec_ready); end
    @(negedge clk); clear = 1'b0; rec_valid = 1'b0;
    model.delete();
    checks++; if (count !== '0) begin errors++; $display("FAIL clr_rec_count got %0d want 0", count); end
    record(4'd6, 2'd3);
    @(negedge clk); stop = 1'b1; play_start = 1'b1; clear = 1'b1;
    @(negedge clk); stop = 1'b0; play_start = 1'b0; clear = 1'b0;
    @(negedge clk);
    checks++; if (play_valid !== 1'b0 || done !== 1'b0 || count !== 5'd1) begin errors++;
      $display("FAIL stop_prio got pv %0b done %0b count %0d want 0 0 1", play_valid, done, count); end
    @(negedge clk); play_start = 1'b1; rec_valid = 1'b1; note_in = 4'd1;
    @(negedge clk); play_start = 1'b0; rec_valid = 1'b0;
    checks++; if (count !== 5'd1 || play_idx !== '0) begin errors++;
      $display("FAIL start_prio got count %0d idx %0d want 1 0", count, play_idx); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loop();
    do_clear();
    record(4'd2, 2'd1); record(4'd11, 2'd2);
    loop_i = 1'b1;
`ifdef SEQ_LOOP_EN
    @(negedge clk); tick_len = '0; play_start = 1'b1;
    @(negedge clk); play_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++; if (play_valid !== 1'b0 || done !== 1'b0 || play_idx !== AW'(i % 2)) begin errors++;
        $display("FAIL loop_gap step %0d got pv %0b done %0b idx %0d", i, play_valid, done, play_idx); end
      @(negedge clk);
      checks++; if (play_valid !== 1'b1 || done !== 1'b0 || note_out !== model[i % 2].note) begin errors++;
        $display("FAIL loop_note step %0d got pv %0b done %0b note %0d want 1 0 %0d",
                 i, play_valid, done, note_out, model[i % 2].note); end
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk); stop = 1'b0;
    checks++; if (play_valid !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL loop_stop got pv %0b done %0b want 0 0", play_valid, done); end
    @(negedge clk);
`else
    test_playback(0);
`endif
    loop_i = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      int n = $urandom_range(1, DEPTH);
      do_clear();
      for (int i = 0; i < n; i++) record(NOTE_W'($urandom), OCT_W'($urandom));
      checks++; if (count !== (AW+1)'(n)) begin errors++; $display("FAIL rand_count got %0d want %0d", count, n); end
      test_playback($urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_mid_hold();
    do_clear();
    record(4'd13, 2'd3); record(4'd4, 2'd2);
    @(negedge clk); tick_len = 24'd5; play_start = 1'b1;
    @(negedge clk); play_start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (play_valid !== 1'b1) begin errors++; $display("FAIL rst_pre got pv %0b want 1", play_valid); end
    #1 reset = 1'b1;
    #1;
    checks++; if ({play_valid, note_out, octave_out, play_idx, count, done} !== '0) begin errors++;
      $display("FAIL rst_mid got pv %0b note %0d oct %0d idx %0d count %0d done %0b want all 0",
               play_valid, note_out, octave_out, play_idx, count, done); end
    @(negedge clk); reset = 1'b0;
    model.delete();
    repeat (3) begin
      @(negedge clk);
      checks++; if (done !== 1'b0 || play_valid !== 1'b0) begin errors++;
        $display("FAIL rst_nodone got done %0b pv %0b want 0 0", done, play_valid); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rec_valid = 0; clear = 0; play_start = 0; stop = 0; loop_i = 0;
    note_in = '0; octave_in = '0; tick_len = '0;
    test_reset();
    test_directed_notes();
    test_full();
    test_empty_play();
    test_stop();
    test_priority();
    test_loop();
    test_random();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
